// File: rtl/sdma_inst_assembler.sv
// Collects BEAT_W-bit beats into INST_W-bit SDMA instructions and queues them
// in a first-word-fall-through FIFO that feeds the instruction decoder.
`ifndef SDMA_INSTWIDTH
`define SDMA_INSTWIDTH 512
`endif

module sdma_inst_assembler #(
  parameter  int INST_W = `SDMA_INSTWIDTH,
  parameter  int BEAT_W = 32,
  parameter  int DEPTH  = 4,
  localparam int NBEAT  = (INST_W + BEAT_W - 1) / BEAT_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sia_flush,
  input  logic              i_sia_beat_vld,
  output logic              o_sia_beat_rdy,
  input  logic [BEAT_W-1:0] i_sia_beat,
  input  logic              i_sia_beat_last,
  output logic              o_sia_inst_vld,
  input  logic              i_sia_inst_rdy,
  output logic [INST_W-1:0] o_sia_inst,
  output logic [CNT_W-1:0]  o_sia_cnt,
  output logic              o_sia_err,
  output logic              o_sia_idle
);

  localparam int BC_W  = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(NBEAT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_COLLECT} state_e;

  state_e            state_q, state_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic              err_q, err_d;
  logic              rdy_en_q;
  logic [BEAT_W-1:0] slot_q [NBEAT];
  logic [INST_W-1:0] mem_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              beat_acc, push, pop;
  logic [INST_W-1:0] push_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // rdy_en_q holds beat_rdy low while reset is asserted and releases it one edge later.
  assign o_sia_beat_rdy = rdy_en_q && !i_sia_flush && (cnt_q < CNT_W'(DEPTH));
  assign beat_acc       = i_sia_beat_vld && o_sia_beat_rdy;
  assign o_sia_inst_vld = (cnt_q != '0);
  assign pop            = o_sia_inst_vld && i_sia_inst_rdy;
  assign o_sia_cnt      = cnt_q;
  assign o_sia_err      = err_q;
  assign o_sia_idle     = (cnt_q == '0) && (state_q == S_IDLE);
  assign o_sia_inst     = o_sia_inst_vld ? mem_q[rd_ptr_q] : '0;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    push    = 1'b0;
    err_d   = 1'b0;
    if (beat_acc) begin
      if (bc_q == BC_LAST) begin
        bc_d    = '0;
        state_d = S_IDLE;
        push    = i_sia_beat_last;
        err_d   = !i_sia_beat_last;
      end else if (i_sia_beat_last) begin
        bc_d    = '0;
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        bc_d    = bc_q + BC_W'(1);
        state_d = S_COLLECT;
      end
    end
    if (i_sia_flush) begin
      bc_d    = '0;
      state_d = S_IDLE;
    end
  end

  // Final beat bypasses the slot registers; bits above INST_W are simply not mapped.
  always_comb begin
    push_word = '0;
    for (int k = 0; k < NBEAT; k++) begin
      for (int j = 0; j < BEAT_W; j++) begin
        if (k * BEAT_W + j < INST_W)
          push_word[k*BEAT_W+j] = (BC_W'(k) == bc_q) ? i_sia_beat[j] : slot_q[k][j];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      bc_q     <= '0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      bc_q     <= bc_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
      if (i_sia_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  // NOTE: data storage is not reset; occupancy and the gated output make stale contents invisible.
  always_ff @(posedge i_clk) begin
    if (beat_acc) slot_q[bc_q] <= i_sia_beat;
    if (push)     mem_q[wr_ptr_q] <= push_word;
  end

endmodule

// File: tb/tb_sdma_inst_assembler.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed framing/flush/full cases and an INST_W=80 instance.
module tb_sdma_inst_assembler;

  localparam int NB    = 16;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic         flush, vld, last, inst_rdy;
  logic [31:0]  beat;
  logic         rdy_o, inst_vld, err, idle;
  logic [511:0] inst;
  logic [2:0]   cnt;

  logic         w_rst_n, w_vld, w_last, w_inst_rdy;
  logic [31:0]  w_beat;
  logic         w_rdy_o, w_inst_vld, w_err, w_idle;
  logic [79:0]  w_inst;
  logic [2:0]   w_cnt;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  sdma_inst_assembler #(.INST_W(512), .BEAT_W(32), .DEPTH(DEPTH)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sia_flush(flush),
    .i_sia_beat_vld(vld), .o_sia_beat_rdy(rdy_o), .i_sia_beat(beat),
    .i_sia_beat_last(last), .o_sia_inst_vld(inst_vld), .i_sia_inst_rdy(inst_rdy),
    .o_sia_inst(inst), .o_sia_cnt(cnt), .o_sia_err(err), .o_sia_idle(idle)
  );

  sdma_inst_assembler #(.INST_W(80), .BEAT_W(32), .DEPTH(DEPTH)) u_dut80 (
    .i_clk(clk), .i_rst_n(w_rst_n), .i_sia_flush(1'b0),
    .i_sia_beat_vld(w_vld), .o_sia_beat_rdy(w_rdy_o), .i_sia_beat(w_beat),
    .i_sia_beat_last(w_last), .o_sia_inst_vld(w_inst_vld), .i_sia_inst_rdy(w_inst_rdy),
    .o_sia_inst(w_inst), .o_sia_cnt(w_cnt), .o_sia_err(w_err), .o_sia_idle(w_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of whole instructions and a list of beats of the open frame.
  logic [511:0] mq [$];
  logic [31:0]  fr [$];
  bit           en_m;
  bit           err_m;

  always @(posedge clk or negedge rst_n) begin
    bit           acc, pop_now;
    logic [511:0] w;
    if (!rst_n) begin
      mq.delete();
      fr.delete();
      en_m  = 0;
      err_m = 0;
    end else begin
      err_m   = 0;
      acc     = vld && en_m && !flush && (mq.size() < DEPTH);
      pop_now = (mq.size() > 0) && inst_rdy;
      if (flush) begin
        mq.delete();
        fr.delete();
      end else begin
        if (pop_now) void'(mq.pop_front());
        if (acc) begin
          fr.push_back(beat);
          if (last) begin
            if (fr.size() == NB) begin
              w = '0;
              foreach (fr[k]) w |= 512'(fr[k]) << (32 * k);
              mq.push_back(w);
            end else begin
              err_m = 1;
            end
            fr.delete();
          end else if (fr.size() == NB) begin
            err_m = 1;
            fr.delete();
          end
        end
      end
      en_m = 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("beat_rdy", 512'(rdy_o), 512'(en_m && !flush && (mq.size() < DEPTH)));
      check("inst_vld", 512'(inst_vld), 512'(mq.size() > 0));
      check("cnt", 512'(cnt), 512'(mq.size()));
      check("err", 512'(err), 512'(err_m));
      check("idle", 512'(idle), 512'((mq.size() == 0) && (fr.size() == 0)));
      if (mq.size() > 0) check("inst", inst, mq[0]);
    end
  end

  // Entered just after a posedge; returns 1 time unit after the accepting edge.
  task automatic drive_beat(input logic [31:0] d, input logic l);
    bit seen;
    int n;
    vld = 1'b1; beat = d; last = l; n = 0;
    forever begin
      @(negedge clk); seen = rdy_o;
      @(posedge clk);
      if (seen) break;
      n++;
      if (n > 200) begin
        checks++; failures++;
        $display("FAIL beat_timeout: got no accept expected accept within 200 cycles");
        break;
      end
    end
    #1 vld = 1'b0; last = 1'b0;
  endtask

  // Beat k of frame f carries {f, k}; last is raised on beat index last_at (-1: never).
  task automatic send_frame(input int f, input int nbeats, input int last_at);
    for (int k = 0; k < nbeats; k++)
      drive_beat(32'((f << 16) | k), k == last_at);
  endtask

  task automatic drive_beat80(input logic [31:0] d, input logic l);
    bit seen;
    int n;
    w_vld = 1'b1; w_beat = d; w_last = l; n = 0;
    forever begin
      @(negedge clk); seen = w_rdy_o;
      @(posedge clk);
      if (seen) break;
      n++;
      if (n > 200) begin
        checks++; failures++;
        $display("FAIL beat80_timeout: got no accept expected accept within 200 cycles");
        break;
      end
    end
    #1 w_vld = 1'b0; w_last = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_pct;
    rst_n = 1'b0; w_rst_n = 1'b0;
    flush = 0; vld = 0; last = 0; inst_rdy = 0; beat = '0;
    w_vld = 0; w_last = 0; w_inst_rdy = 0; w_beat = '0;
    #3;
    check("rst_beat_rdy", 512'(rdy_o), 512'(0));
    check("rst_inst_vld", 512'(inst_vld), 512'(0));
    check("rst_inst", inst, 512'(0));
    check("rst_cnt", 512'(cnt), 512'(0));
    check("rst_err", 512'(err), 512'(0));
    check("rst_idle", 512'(idle), 512'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1; w_rst_n = 1'b1; cmp_en = 1;
    @(posedge clk); #1;

    // Single 16-beat instruction, consumer always ready.
    inst_rdy = 1;
    for (int i = 0; i < NB; i++) drive_beat(32'(i), i == NB - 1);
    @(negedge clk);
    check("t1_vld", 512'(inst_vld), 512'(1));
    check("t1_lo", 512'(inst[31:0]), 512'(0));
    check("t1_hi", 512'(inst[511:480]), 512'(32'hF));
    check("t1_cnt1", 512'(cnt), 512'(1));
    @(negedge clk);
    check("t1_cnt0", 512'(cnt), 512'(0));
    @(posedge clk); #1;

    // Five instructions with the consumer stalled: the fifth waits for space.
    inst_rdy = 0;
    for (int f = 1; f <= 4; f++) send_frame(f, NB, NB - 1);
    vld = 1; beat = 32'(5 << 16); last = 0;
    @(negedge clk);
    check("t2_cnt_full", 512'(cnt), 512'(4));
    check("t2_rdy_full", 512'(rdy_o), 512'(0));
    check("t2_head", 512'(inst[31:0]), 512'(32'h0001_0000));
    fork
      send_frame(5, NB, NB - 1);
      begin repeat (3) @(posedge clk); #1 inst_rdy = 1; end
    join
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    check("t2_drained", 512'(cnt), 512'(0));
    @(posedge clk); #1;

    // Early last on beat 7, then a good frame.
    send_frame(8, 7, 6);
    @(negedge clk);
    check("t3_err", 512'(err), 512'(1));
    check("t3_cnt", 512'(cnt), 512'(0));
    check("t3_idle", 512'(idle), 512'(1));
    @(negedge clk);
    check("t3_err_pulse", 512'(err), 512'(0));
    @(posedge clk); #1;
    send_frame(9, NB, NB - 1);
    @(negedge clk);
    check("t3_good_hi", 512'(inst[511:480]), 512'(32'h0009_000F));
    @(posedge clk); #1;

    // Missing last on beat 16.
    send_frame(3, NB, -1);
    @(negedge clk);
    check("t4_err", 512'(err), 512'(1));
    check("t4_cnt", 512'(cnt), 512'(0));
    check("t4_idle", 512'(idle), 512'(1));
    @(posedge clk); #1;

    // Flush with two queued instructions and a partial frame.
    inst_rdy = 0;
    send_frame(1, NB, NB - 1);
    send_frame(2, NB, NB - 1);
    send_frame(7, 5, -1);
    vld = 1; beat = 32'hDEAD_BEEF; flush = 1;
    @(negedge clk);
    check("t5_rdy_flush", 512'(rdy_o), 512'(0));
    @(posedge clk); #1 flush = 0; vld = 0;
    @(negedge clk);
    check("t5_cnt", 512'(cnt), 512'(0));
    check("t5_vld", 512'(inst_vld), 512'(0));
    check("t5_idle", 512'(idle), 512'(1));
    check("t5_err", 512'(err), 512'(0));
    @(posedge clk); #1;

    // Randomised traffic: mostly well-formed frames, varying back-pressure, rare flushes.
    rdy_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rdy_pct = (($urandom_range(0, 2) == 0) ? 10 : (($urandom_range(0, 1) == 0) ? 50 : 90));
      vld = ($urandom_range(0, 9) < 7);
      beat = $urandom;
      if ($urandom_range(0, 49) == 0) last = 1'($urandom_range(0, 1));
      else last = (fr.size() == NB - 1);
      inst_rdy = ($urandom_range(0, 99) < rdy_pct);
      flush = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    vld = 0; last = 0; flush = 0; inst_rdy = 1;
    repeat (8) @(posedge clk);
    #1;

    // Narrow instance: three beats, top half of the final beat discarded.
    drive_beat80(32'hAAAA_1111, 0);
    drive_beat80(32'hBBBB_2222, 0);
    drive_beat80(32'hCCCC_3333, 1);
    @(negedge clk);
    check("t6_vld", 512'(w_inst_vld), 512'(1));
    check("t6_inst", 512'(w_inst), 512'(80'h3333_BBBB2222_AAAA1111));
    check("t6_cnt", 512'(w_cnt), 512'(1));
    check("t6_err", 512'(w_err), 512'(0));
    @(posedge clk); #1;
    drive_beat80(32'h0000_0001, 0);
    @(negedge clk);
    check("t6_busy", 512'(w_idle), 512'(0));
    w_rst_n = 1'b0;
    #1;
    check("t6_rst_idle", 512'(w_idle), 512'(1));
    check("t6_rst_vld", 512'(w_inst_vld), 512'(0));
    check("t6_rst_cnt", 512'(w_cnt), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
